pipe_arb_sched: RTL and testbench
=================================

Name: pipe_arb_sched

Overview:
- Round-robin scheduler that shares one fixed-latency pipelined datapath (a W-wide, H-stage pipe_mem-style delay/adder pipe) between two requesters, A and B.
- Muxes the granted word onto the datapath input and carries a {valid, id} tag pipeline of depth H alongside it.
- Steers each datapath output word into a per-requester result FIFO.
- Credit counters guarantee the FIFOs never overflow, because the external pipe cannot stall.

Parameters:
W, 32, datapath / data word width
H, 5, datapath latency in clock edges (must equal depth of the external pipe, H>=1)
D, 4, result FIFO depth per requester (>=1); also initial credit count

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low reset (reset=0 at a rising edge clears state)
a_valid  in  1  requester A has a word
a_data  in  W  requester A word
a_ready  out  1  A word accepted this cycle
b_valid  in  1  requester B has a word
b_data  in  W  requester B word
b_ready  out  1  B word accepted this cycle
dp_in  out  W  to external pipe input
dp_vld  out  1  dp_in carries a granted word (observability)
dp_out  in  W  from external pipe output
ra_valid  out  1  A result available
ra_data  out  W  A result (FIFO head)
ra_ready  in  1  A consumer pop
rb_valid  out  1  B result available
rb_data  out  W  B result
rb_ready  in  1  B consumer pop
busy  out  1  any tag in flight or any FIFO non-empty

Behaviour:
- Eligibility: elig_x = x_valid && cred_x != 0.
- Arbitration: combinational round-robin.
  - Only one eligible: it wins.
  - Both eligible: the requester not granted last wins.
  - last_grant register updates only on an actual grant. Reset value is B, so A wins the first tie.
- x_ready = grant_x. It is high only in the cycle of the grant, so ready depends on valid.
- dp_in = granted data. dp_in = 0 when there is no grant. dp_vld = grant_a | grant_b.
- Tag pipeline: H-stage shift register of {vld, id}. Stage 0 loads {dp_vld, grant_b} every edge; the last stage aligns with dp_out.
- A word on dp_in at edge k is taken from dp_out at edge k+H and pushed into the FIFO selected by the tag id.
- Latency: grant at edge k → x_valid of the result high after edge k+H. Back-to-back grants give back-to-back results in issue order per requester.
- Credits:
  - cred_x resets to D.
  - −1 on grant_x, +1 on pop (rx_valid && rx_ready). Both in the same cycle: unchanged.
  - Range 0..D, width clog2(D+1).
  - cred_x==0 blocks x only; the other requester is unaffected.
- FIFOs:
  - Depth D, circular read/write pointers with wrap at D, occupancy counter.
  - Push and pop in the same cycle are legal at any occupancy.
  - Credits make push-when-full impossible; a push while full is a design error. Assert it in simulation.
  - rx_data holds the head word.
  - Data must not change while rx_valid=1 and rx_ready=0.
- Pop while empty is ignored.
- Reset values: a_ready=b_ready=0 (no grants during reset), dp_in=0, dp_vld=0, all tags invalid, ra_valid=rb_valid=0, ra_data=rb_data=0, busy=0, cred=D, pointers=0.
- Reset mid-operation: all in-flight tags are dropped. Stale words later emerging from dp_out are ignored because their tags are invalid, and the FIFOs stay empty.
- busy = any tag vld | ra_valid | rb_valid.

Test Plan:
1. Reset=0 for 1 cycle, then A issues 'hFFFFFFFF at edge 2 (H=5) → a_ready=1 that cycle; dp_in='hFFFFFFFF; ra_valid rises after edge 7 with ra_data='hFFFFFFFF; rb_valid stays 0.
2. A and B both valid continuously (A='hAAAAFFFF, B='h0000FFFF), both ready=1 → grants alternate A,B,A,B starting with A; results alternate in the two FIFOs, each exactly H edges after its grant.
3. A valid for 6 cycles, ra_ready=0, D=4 → exactly 4 grants, then a_ready=0 with cred_a=0. Pop one (ra_ready=1 for 1 cycle) → next cycle one more grant. Meanwhile B is still granted every cycle it asks.
4. FIFO A holds 3 words; push (result arrives) and pop in the same cycle → occupancy stays 3; order is preserved across pointer wrap for 10 sequential words 'h0000AAAA+i.
5. 3 words in flight; reset asserted 1 cycle at edge 3 → no ra_valid/rb_valid for the next 2H cycles despite dp_out carrying stale words; cred=D; busy=0.
6. Idle with no requests → dp_vld=0, dp_in=0, busy=0 indefinitely; last_grant unchanged.

Source files
------------

// File: rtl/pipe_arb_sched.sv
// pipe_arb_sched: round-robin scheduler sharing one fixed-latency external
// pipe between requesters A and B. A {vld,id} tag rides alongside each issued
// word, and credit counters keep the per-requester result FIFOs from
// overflowing, because the external pipe cannot stall.
module pipe_arb_sched #(
    parameter int W = 32,
    parameter int H = 5,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         a_valid,
    input  logic [W-1:0] a_data,
    output logic         a_ready,
    input  logic         b_valid,
    input  logic [W-1:0] b_data,
    output logic         b_ready,
    output logic [W-1:0] dp_in,
    output logic         dp_vld,
    input  logic [W-1:0] dp_out,
    output logic         ra_valid,
    output logic [W-1:0] ra_data,
    input  logic         ra_ready,
    output logic         rb_valid,
    output logic [W-1:0] rb_data,
    input  logic         rb_ready,
    output logic         busy
);

    localparam int CW = $clog2(D + 1);
    localparam int PW = (D > 1) ? $clog2(D) : 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(D);
    localparam logic [PW-1:0] PTR_LAST = PW'(D - 1);

    // Index 0 is requester A, index 1 is requester B.
    logic [CW-1:0] r_cred [2];
    logic          r_last_b;
    logic [H-1:0]  r_tag_vld;
    logic [H-1:0]  r_tag_id;
    logic [W-1:0]  r_mem  [2][D];
    logic [PW-1:0] r_wp   [2];
    logic [PW-1:0] r_rp   [2];
    logic [CW-1:0] r_cnt  [2];

    logic          w_elig_a;
    logic          w_elig_b;
    logic [1:0]    w_grant;
    logic [1:0]    w_push;
    logic [1:0]    w_pop;
    logic [1:0]    w_rvalid;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    // Eligibility, round-robin grant, datapath mux, FIFO heads and status.
    always_comb begin
        w_elig_a   = reset && a_valid && (r_cred[0] != '0);
        w_elig_b   = reset && b_valid && (r_cred[1] != '0);
        w_grant[0] = w_elig_a && (!w_elig_b || r_last_b);
        w_grant[1] = w_elig_b && (!w_elig_a || !r_last_b);
        a_ready    = w_grant[0];
        b_ready    = w_grant[1];
        dp_vld     = w_grant[0] | w_grant[1];
        if (w_grant[0])      dp_in = a_data;
        else if (w_grant[1]) dp_in = b_data;
        else                 dp_in = '0;
        w_push[0]   = r_tag_vld[H-1] && !r_tag_id[H-1];
        w_push[1]   = r_tag_vld[H-1] &&  r_tag_id[H-1];
        w_rvalid[0] = (r_cnt[0] != '0);
        w_rvalid[1] = (r_cnt[1] != '0);
        w_pop[0]    = w_rvalid[0] && ra_ready;
        w_pop[1]    = w_rvalid[1] && rb_ready;
        ra_valid    = w_rvalid[0];
        rb_valid    = w_rvalid[1];
        ra_data     = w_rvalid[0] ? r_mem[0][r_rp[0]] : '0;
        rb_data     = w_rvalid[1] ? r_mem[1][r_rp[1]] : '0;
        busy        = (|r_tag_vld) | w_rvalid[0] | w_rvalid[1];
    end

    // Remember who won the last actual grant; reset favours A on the first tie.
    always_ff @(posedge clk) begin
        if (!reset)          r_last_b <= 1'b1;
        else if (w_grant[0]) r_last_b <= 1'b0;
        else if (w_grant[1]) r_last_b <= 1'b1;
    end

    // Credits: one per free FIFO slot not already claimed by an in-flight word.
    always_ff @(posedge clk) begin
        for (int unsigned q = 0; q < 2; q++) begin
            if (!reset)
                r_cred[q] <= DEPTH_C;
            else if (w_grant[q] && !w_pop[q])
                r_cred[q] <= r_cred[q] - CW'(1);
            else if (!w_grant[q] && w_pop[q])
                r_cred[q] <= r_cred[q] + CW'(1);
        end
    end

    // Tag shift register; the last stage lines up with dp_out.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tag_vld <= '0;
            r_tag_id  <= '0;
        end else begin
            r_tag_vld[0] <= dp_vld;
            r_tag_id[0]  <= w_grant[1];
            for (int unsigned i = 1; i < H; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag_id[i]  <= r_tag_id[i-1];
            end
        end
    end

    // Result FIFOs: circular pointers wrapping at D plus an occupancy count.
    always_ff @(posedge clk) begin
        for (int unsigned q = 0; q < 2; q++) begin
            if (!reset) begin
                r_wp[q]  <= '0;
                r_rp[q]  <= '0;
                r_cnt[q] <= '0;
            end else begin
                if (w_push[q]) begin
                    r_mem[q][r_wp[q]] <= dp_out;
                    r_wp[q]           <= f_inc(r_wp[q]);
                end
                if (w_pop[q])
                    r_rp[q] <= f_inc(r_rp[q]);
                if (w_push[q] && !w_pop[q])
                    r_cnt[q] <= r_cnt[q] + CW'(1);
                else if (!w_push[q] && w_pop[q])
                    r_cnt[q] <= r_cnt[q] - CW'(1);
            end
        end
    end

    a_no_overflow_a: assert property (@(posedge clk) disable iff (!reset)
        !(w_push[0] && r_cnt[0] == DEPTH_C));
    a_no_overflow_b: assert property (@(posedge clk) disable iff (!reset)
        !(w_push[1] && r_cnt[1] == DEPTH_C));

endmodule

// File: tb/tb_pipe_arb_sched.sv
// Bench for pipe_arb_sched: an ideal H-stage external pipe, a queue-based
// scoreboard model checked every cycle, and directed scenarios with literal
// expectations.
module tb_pipe_arb_sched;

    localparam int W = 32;
    localparam int H = 5;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset, a_valid, b_valid, ra_ready, rb_ready;
    logic [W-1:0] a_data, b_data;
    logic         a_ready, b_ready, dp_vld, ra_valid, rb_valid, busy;
    logic [W-1:0] dp_in, dp_out, ra_data, rb_data;

    always #5 clk = ~clk;

    pipe_arb_sched #(.W(W), .H(H), .D(D)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .dp_in(dp_in), .dp_vld(dp_vld), .dp_out(dp_out),
        .ra_valid(ra_valid), .ra_data(ra_data), .ra_ready(ra_ready),
        .rb_valid(rb_valid), .rb_data(rb_data), .rb_ready(rb_ready),
        .busy(busy)
    );

    // External pipe: pure H-edge delay, never reset, so stale words survive.
    logic [W-1:0] pipe [H];
    logic [W-1:0] dp_s;
    initial begin
        for (int i = 0; i < H; i++) pipe[i] = '0;
        dp_s = '0;
    end
    always @(negedge clk) dp_s = dp_in;
    always @(posedge clk) begin
        pipe[0] <= dp_s;
        for (int i = 1; i < H; i++) pipe[i] <= pipe[i-1];
    end
    assign dp_out = pipe[H-1];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard model: words in flight with their due edge, result queues, credits.
    typedef struct { int due; bit id; logic [W-1:0] d; } fl_t;
    fl_t          infl [$];
    logic [W-1:0] qa [$];
    logic [W-1:0] qb [$];
    int           m_cred_a = D;
    int           m_cred_b = D;
    bit           m_last_b = 1'b1;
    int           edge_n   = 0;

    function automatic bit win_a();
        bit ea = (reset === 1'b1) && (a_valid === 1'b1) && (m_cred_a > 0);
        bit eb = (reset === 1'b1) && (b_valid === 1'b1) && (m_cred_b > 0);
        if (ea && eb) return !(!m_last_b);
        return ea;
    endfunction

    function automatic bit win_b();
        bit ea = (reset === 1'b1) && (a_valid === 1'b1) && (m_cred_a > 0);
        bit eb = (reset === 1'b1) && (b_valid === 1'b1) && (m_cred_b > 0);
        if (ea && eb) return !m_last_b;
        return eb;
    endfunction

    always @(posedge clk) begin
        bit  g_a, g_b, p_a, p_b;
        fl_t e;
        g_a = win_a();
        g_b = win_b();
        p_a = (qa.size() > 0) && (ra_ready === 1'b1);
        p_b = (qb.size() > 0) && (rb_ready === 1'b1);
        if (reset !== 1'b1) begin
            infl.delete(); qa.delete(); qb.delete();
            m_cred_a = D; m_cred_b = D; m_last_b = 1'b1;
        end else begin
            if (p_a) begin void'(qa.pop_front()); m_cred_a++; end
            if (p_b) begin void'(qb.pop_front()); m_cred_b++; end
            while (infl.size() > 0 && infl[0].due == edge_n) begin
                e = infl.pop_front();
                if (e.id) qb.push_back(e.d);
                else      qa.push_back(e.d);
            end
            if (g_a) begin infl.push_back('{edge_n + H, 1'b0, a_data}); m_cred_a--; m_last_b = 1'b0; end
            if (g_b) begin infl.push_back('{edge_n + H, 1'b1, b_data}); m_cred_b--; m_last_b = 1'b1; end
        end
        edge_n++;
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        bit           g_a, g_b;
        logic [W-1:0] exp_dp, exp_ra, exp_rb;
        g_a = win_a();
        g_b = win_b();
        exp_dp = g_a ? a_data : (g_b ? b_data : '0);
        exp_ra = '0;
        exp_rb = '0;
        if (qa.size() > 0) exp_ra = qa[0];
        if (qb.size() > 0) exp_rb = qb[0];
        chk("m_a_ready",  a_ready,  g_a);
        chk("m_b_ready",  b_ready,  g_b);
        chk("m_dp_vld",   dp_vld,   g_a | g_b);
        chk("m_dp_in",    dp_in,    exp_dp);
        chk("m_ra_valid", ra_valid, qa.size() > 0);
        chk("m_ra_data",  ra_data,  exp_ra);
        chk("m_rb_valid", rb_valid, qb.size() > 0);
        chk("m_rb_data",  rb_data,  exp_rb);
        chk("m_busy",     busy,     (infl.size() > 0) || (qa.size() > 0) || (qb.size() > 0));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        a_valid = 0; b_valid = 0;
        reset = 0;
        tick();
        reset = 1;
    endtask

    initial begin
        int na, issued, popped;
        bit ar;
        reset = 0; a_valid = 0; b_valid = 0; a_data = '0; b_data = '0;
        ra_ready = 0; rb_ready = 0;
        tick();

        // 1: single A word, latency H
        reset = 1; a_valid = 1; a_data = 32'hFFFFFFFF;
        @(negedge clk);
        chk("t1_a_ready", a_ready, 1);
        chk("t1_dp_in", dp_in, 32'hFFFFFFFF);
        tick();
        a_valid = 0;
        repeat (4) tick();
        ra_ready = 1;
        @(negedge clk);
        chk("t1_ra_valid_early", ra_valid, 0);
        tick();
        @(negedge clk);
        chk("t1_ra_valid", ra_valid, 1);
        chk("t1_ra_data", ra_data, 32'hFFFFFFFF);
        chk("t1_rb_valid", rb_valid, 0);
        tick();
        @(negedge clk);
        chk("t1_popped", ra_valid, 0);
        ra_ready = 0;

        // 2: continuous contention alternates A,B
        rst_pulse();
        ra_ready = 1; rb_ready = 1;
        a_valid = 1; b_valid = 1; a_data = 32'hAAAAFFFF; b_data = 32'h0000FFFF;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t2_a_ready", a_ready, (i % 2) == 0);
            chk("t2_b_ready", b_ready, (i % 2) == 1);
            if (i == 5) chk("t2_ra_not_yet", ra_valid, 0);
            if (i == 6) begin
                chk("t2_ra_valid", ra_valid, 1);
                chk("t2_ra_data", ra_data, 32'hAAAAFFFF);
                chk("t2_rb_not_yet", rb_valid, 0);
            end
            if (i == 7) chk("t2_rb_data", rb_data, 32'h0000FFFF);
            tick();
        end
        a_valid = 0; b_valid = 0;
        repeat (H + 3) tick();

        // 3: credit exhaustion blocks A only
        rst_pulse();
        ra_ready = 0; rb_ready = 1; na = 0;
        for (int i = 0; i < 6; i++) begin
            a_valid = 1; a_data = 32'h000000A0 + i;
            b_valid = (i >= 4); b_data = 32'h0000BBB0 + i;
            @(negedge clk);
            na += int'(a_ready);
            if (i >= 4) chk("t3_b_ready", b_ready, 1);
            tick();
        end
        chk("t3_a_grants", na, 4);
        b_valid = 0; a_data = 32'h000000A6;
        @(negedge clk);
        chk("t3_a_blocked", a_ready, 0);
        tick();
        ra_ready = 1;
        @(negedge clk);
        chk("t3_a_blocked2", a_ready, 0);
        tick();
        ra_ready = 0;
        @(negedge clk);
        chk("t3_a_regrant", a_ready, 1);
        tick();
        a_valid = 0; ra_ready = 1;
        repeat (2 * H + D) tick();
        ra_ready = 0;

        // 4: simultaneous push/pop at occupancy 3, order across pointer wrap
        rst_pulse();
        issued = 0; popped = 0;
        for (int c = 0; c < 80 && popped < 10; c++) begin
            a_valid  = (issued < 10);
            a_data   = 32'h0000AAAA + issued;
            ra_ready = (c >= 8);
            @(negedge clk);
            ar = a_ready;
            if (ra_valid && ra_ready) begin
                chk("t4_order", ra_data, 32'h0000AAAA + popped);
                popped++;
            end
            tick();
            if (ar) issued++;
        end
        chk("t4_popped", popped, 10);
        a_valid = 0;
        repeat (H + 2) tick();
        ra_ready = 0;

        // 5: reset with words in flight drops them
        rst_pulse();
        a_valid = 1; b_valid = 1; a_data = 32'h5A5A0001; b_data = 32'h5A5A0002;
        repeat (3) tick();
        a_valid = 0; b_valid = 0;
        reset = 0;
        tick();
        reset = 1;
        // 6: idle, nothing emerges, nothing asserted
        for (int i = 0; i < 2 * H; i++) begin
            @(negedge clk);
            chk("t5_ra_valid", ra_valid, 0);
            chk("t5_rb_valid", rb_valid, 0);
            chk("t5_busy", busy, 0);
            chk("t6_dp_vld", dp_vld, 0);
            chk("t6_dp_in", dp_in, 0);
            tick();
        end
        a_valid = 1; b_valid = 1; a_data = 32'h00000A00; b_data = 32'h00000B00;
        @(negedge clk);
        chk("t6_tie_a", a_ready, 1);
        chk("t6_tie_b", b_ready, 0);
        tick();
        b_valid = 0; na = 1;
        for (int i = 0; i < 5; i++) begin
            a_data = 32'h00000A01 + i;
            @(negedge clk);
            na += int'(a_ready);
            tick();
        end
        chk("t5_cred_full", na, 4);
        a_valid = 0; ra_ready = 1; rb_ready = 1;
        repeat (2 * H) tick();

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
